// File: rtl/prbs_gen_multi.sv
// Pattern source for the link test path: a programmable preamble repeated n times,
// followed by a PRBS7/15/23/31 stream, issued as DATA_W-bit words over valid/ready.
module prbs_gen_multi #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 32,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [CNT_W-1:0]  n,
  input  logic              err_inj,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] prbs_out,
  output logic              in_prbs,
  output logic              busy
);

  localparam int NCHUNK  = PAT_W / DATA_W;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PRBS} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [30:0]       lfsr;
  } step_t;

  // Runs the Fibonacci LFSR for DATA_W bits; first generated bit lands in the MSB.
  // Bits above k-1 are never tapped, so a full 31-bit shift serves every length.
  function automatic step_t prbs_step(input logic [30:0] seed, input logic [1:0] m);
    step_t r;
    logic  fb;
    r.lfsr = seed;
    r.word = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      case (m)
        2'b00:   fb = r.lfsr[6]  ^ r.lfsr[5];
        2'b01:   fb = r.lfsr[14] ^ r.lfsr[13];
        2'b10:   fb = r.lfsr[22] ^ r.lfsr[17];
        default: fb = r.lfsr[30] ^ r.lfsr[27];
      endcase
      r.word[i] = fb;
      r.lfsr    = {r.lfsr[29:0], fb};
    end
    return r;
  endfunction

  state_t             state_q, state_nxt;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   n_q, rep_cnt;
  logic [PAT_W-1:0]   pattern_q;
  logic [CHUNK_W-1:0] chunk_idx;
  logic [30:0]        lfsr_q;
  logic               err_flag, stop_seen;

  // In IDLE the next word is derived from the live inputs and a fresh seed,
  // so the first word can be registered on the same edge that samples start.
  logic               src_idle;
  logic [30:0]        src_lfsr;
  logic [1:0]         src_mode;
  logic [PAT_W-1:0]   src_pat;
  logic [CNT_W-1:0]   src_n, src_rep;
  logic [CHUNK_W-1:0] src_idx;
  step_t              step;

  assign src_idle = (state_q == S_IDLE);
  assign src_lfsr = src_idle ? '1 : lfsr_q;
  assign src_mode = src_idle ? mode : mode_q;
  assign src_pat  = src_idle ? pattern : pattern_q;
  assign src_n    = src_idle ? n : n_q;
  assign src_rep  = src_idle ? '0 : rep_cnt;
  assign src_idx  = src_idle ? '0 : chunk_idx;
  assign step     = prbs_step(src_lfsr, src_mode);

  logic accept, stop_now, gen_prbs, load, err_pend;

  assign accept   = out_valid & out_ready;
  assign stop_now = stop | stop_seen;
  assign gen_prbs = (state_q == S_PRBS) | (src_rep == src_n);
  assign load     = src_idle ? start : (accept & ~stop_now);
  assign err_pend = ~src_idle & (err_flag | err_inj);
  assign busy     = ~src_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so every path through the case assigns and no latch is inferred.
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (start)  state_nxt = gen_prbs ? S_PRBS : S_PRE;
      S_PRE:  if (accept) state_nxt = stop_now ? S_IDLE : (gen_prbs ? S_PRBS : S_PRE);
      S_PRBS: if (accept && stop_now) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [DATA_W-1:0]  chunk_word, word_nxt;
  logic [CHUNK_W-1:0] idx_nxt;
  logic [CNT_W-1:0]   rep_nxt;
  logic               last_chunk;

  always_comb begin
    chunk_word = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (src_idx == CHUNK_W'(c)) chunk_word = src_pat[(NCHUNK-1-c)*DATA_W +: DATA_W];
    end
    last_chunk = (src_idx == CHUNK_W'(NCHUNK - 1));
    idx_nxt    = last_chunk ? '0 : src_idx + CHUNK_W'(1);
    rep_nxt    = last_chunk ? src_rep + CNT_W'(1) : src_rep;
    word_nxt   = gen_prbs ? (step.word ^ DATA_W'(err_pend)) : chunk_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      prbs_out  <= '0;
      in_prbs   <= 1'b0;
      mode_q    <= '0;
      n_q       <= '0;
      pattern_q <= '0;
      chunk_idx <= '0;
      rep_cnt   <= '0;
      lfsr_q    <= '1;
      err_flag  <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; a later assignment in this block overrides an earlier one.
      if (src_idle && start) begin
        mode_q    <= mode;
        n_q       <= n;
        pattern_q <= pattern;
        lfsr_q    <= '1;
        chunk_idx <= '0;
        rep_cnt   <= '0;
      end

      if (load) begin
        out_valid <= 1'b1;
        prbs_out  <= word_nxt;
        in_prbs   <= gen_prbs;
        if (gen_prbs) begin
          lfsr_q <= step.lfsr;
        end else begin
          chunk_idx <= idx_nxt;
          rep_cnt   <= rep_nxt;
        end
      end else if (!src_idle && accept) begin
        out_valid <= 1'b0;
        in_prbs   <= 1'b0;
      end

      if (src_idle || (load && gen_prbs)) err_flag <= 1'b0;
      else if (err_inj)                   err_flag <= 1'b1;

      if (src_idle || accept) stop_seen <= 1'b0;
      else if (stop)          stop_seen <= 1'b1;
    end
  end

endmodule
